// File: rtl/branch_pkg.sv
// Shared encodings for the branch predictor: resolved-transfer kinds and
// 2-bit saturating counter states.
package branch_pkg;

    typedef enum logic [1:0] {
        BR_NONE   = 2'b00,
        BR_COND   = 2'b01,
        BR_REG    = 2'b10,
        BR_UNCOND = 2'b11
    } br_kind_e;

    localparam logic [1:0] STRONG_NT = 2'd0;
    localparam logic [1:0] WEAK_NT   = 2'd1;
    localparam logic [1:0] WEAK_T    = 2'd2;
    localparam logic [1:0] STRONG_T  = 2'd3;

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch/resolve bundle between the pipeline (master) and the branch predictor (slave).
interface branch_predict_unit_if
    import branch_pkg::*;
#(
    parameter int unsigned XLEN = 32
);
    logic            stall;
    logic            res_valid;
    br_kind_e        res_kind;
    logic            res_ps;
    logic            res_zero;
    logic [XLEN-1:0] res_pc;
    logic [XLEN-1:0] res_target;
    logic            res_pred_taken;
    logic [XLEN-1:0] res_pred_target;

    logic [XLEN-1:0] pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            flush;
    logic            flush_delay;
    logic [15:0]     mispredict_cnt;

    modport master (
        output stall, res_valid, res_kind, res_ps, res_zero, res_pc, res_target,
               res_pred_taken, res_pred_target,
        input  pc, pred_taken, pred_target, flush, flush_delay, mispredict_cnt
    );

    modport slave (
        input  stall, res_valid, res_kind, res_ps, res_zero, res_pc, res_target,
               res_pred_taken, res_pred_target,
        output pc, pred_taken, pred_target, flush, flush_delay, mispredict_cnt
    );
endinterface

// File: rtl/branch_btb.sv
// Direct-mapped branch target buffer: combinational lookup by fetch pc,
// synchronous update by resolving pc. Only valid bits are reset.
module branch_btb
    import branch_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned BTB_DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] rd_pc,
    output logic            rd_hit,
    output logic [1:0]      rd_ctr,
    output logic [XLEN-1:0] rd_target,
    input  logic            wr_en,
    input  logic [XLEN-1:0] wr_pc,
    input  logic            wr_taken,
    input  logic            wr_strong,
    input  logic [XLEN-1:0] wr_target
);
    localparam int unsigned IDX   = $clog2(BTB_DEPTH);
    localparam int unsigned TAG_W = XLEN - IDX;

    logic [BTB_DEPTH-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q    [BTB_DEPTH];
    logic [XLEN-1:0]      target_q [BTB_DEPTH];
    logic [1:0]           ctr_q    [BTB_DEPTH];

    logic [IDX-1:0]   rd_idx;
    logic [IDX-1:0]   wr_idx;
    logic [TAG_W-1:0] wr_tag;
    logic             wr_hit_c;
    logic             wr_commit_c;
    logic [1:0]       ctr_cur;
    logic [1:0]       ctr_nxt_c;

    assign rd_idx    = rd_pc[IDX-1:0];
    assign rd_hit    = valid_q[rd_idx] && (tag_q[rd_idx] == rd_pc[XLEN-1:IDX]);
    assign rd_ctr    = ctr_q[rd_idx];
    assign rd_target = target_q[rd_idx];

    assign wr_idx      = wr_pc[IDX-1:0];
    assign wr_tag      = wr_pc[XLEN-1:IDX];
    assign wr_hit_c    = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);
    assign ctr_cur     = ctr_q[wr_idx];
    // A not-taken miss leaves the entry untouched; everything else writes it.
    assign wr_commit_c = wr_en && (wr_hit_c || wr_taken);

    always_comb begin
        ctr_nxt_c = ctr_cur;
        if (wr_strong) begin
            ctr_nxt_c = STRONG_T;
        end else if (!wr_hit_c) begin
            ctr_nxt_c = WEAK_T;
        end else if (wr_taken) begin
            ctr_nxt_c = (ctr_cur == STRONG_T) ? STRONG_T : ctr_cur + 2'd1;
        end else begin
            ctr_nxt_c = (ctr_cur == STRONG_NT) ? STRONG_NT : ctr_cur - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_commit_c) begin
            valid_q[wr_idx] <= 1'b1;
            tag_q[wr_idx]   <= wr_tag;
            ctr_q[wr_idx]   <= ctr_nxt_c;
            if (wr_taken) begin
                target_q[wr_idx] <= wr_target;
            end
        end
    end
endmodule

// File: rtl/branch_predict_unit.sv
// Fetch PC generator with BTB-based prediction, mispredict detection/flush
// and a saturating mispredict counter.
module branch_predict_unit
    import branch_pkg::*;
#(
    parameter int unsigned    XLEN      = 32,
    parameter int unsigned    BTB_DEPTH = 16,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input logic                 clk,
    input logic                 rst,
    branch_predict_unit_if.slave bus
);
    localparam int unsigned CNT_W = 16;

    logic            btb_hit;
    logic [1:0]      btb_ctr;
    logic [XLEN-1:0] btb_target;

    logic [XLEN-1:0]  pc_q;
    logic [XLEN-1:0]  pc_d;
    logic             flush_delay_q;
    logic [CNT_W-1:0] cnt_q;

    logic            act_taken_c;
    logic            mispredict_c;
    logic            btb_wr_c;
    logic            btb_strong_c;
    logic            pred_taken_c;
    logic [XLEN-1:0] pred_target_c;

    branch_btb #(
        .XLEN      (XLEN),
        .BTB_DEPTH (BTB_DEPTH)
    ) u_btb (
        .clk       (clk),
        .rst       (rst),
        .rd_pc     (pc_q),
        .rd_hit    (btb_hit),
        .rd_ctr    (btb_ctr),
        .rd_target (btb_target),
        .wr_en     (btb_wr_c),
        .wr_pc     (bus.res_pc),
        .wr_taken  (act_taken_c),
        .wr_strong (btb_strong_c),
        .wr_target (bus.res_target)
    );

    // Resolve-side decode: actual direction and mispredict.
    always_comb begin
        act_taken_c = 1'b0;
        case (bus.res_kind)
            BR_COND:           act_taken_c = bus.res_ps ^ bus.res_zero;
            BR_REG, BR_UNCOND: act_taken_c = 1'b1;
            default:           act_taken_c = 1'b0;
        endcase
        mispredict_c = bus.res_valid &&
                       ((act_taken_c != bus.res_pred_taken) ||
                        (act_taken_c && bus.res_pred_taken &&
                         (bus.res_target != bus.res_pred_target)));
        btb_wr_c     = bus.res_valid && (bus.res_kind != BR_NONE);
        btb_strong_c = (bus.res_kind == BR_REG) || (bus.res_kind == BR_UNCOND);
    end

    assign pred_taken_c  = btb_hit && (btb_ctr >= WEAK_T);
    assign pred_target_c = btb_hit ? btb_target : pc_q + XLEN'(1);

    // Redirect beats stall, stall beats prediction.
    always_comb begin
        pc_d = pc_q + XLEN'(1);
        if (mispredict_c) begin
            pc_d = act_taken_c ? bus.res_target : bus.res_pc + XLEN'(1);
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (pred_taken_c) begin
            pc_d = pred_target_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            flush_delay_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            pc_q          <= pc_d;
            flush_delay_q <= mispredict_c;
            if (mispredict_c && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.pc             = pc_q;
    assign bus.pred_taken     = pred_taken_c;
    assign bus.pred_target    = pred_target_c;
    assign bus.flush          = mispredict_c;
    assign bus.flush_delay    = flush_delay_q;
    assign bus.mispredict_cnt = cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: directed scenarios then random
// traffic, checked against a behavioural model of pc/BTB/flush behaviour.
module tb_branch_predict_unit;
    import branch_pkg::*;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned DEPTH    = 16;
    localparam logic [31:0] RESET_PC = 32'h0;

    typedef struct {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] ptgt;
        logic        fl;
        logic        fd;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    branch_predict_unit_if #(.XLEN(XLEN)) bus ();

    branch_predict_unit #(
        .XLEN      (XLEN),
        .BTB_DEPTH (DEPTH),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;
    exp_t        exp_q[$];

    // Reference model state
    bit [31:0]   m_pc;
    bit          m_fd;
    int unsigned m_cnt;
    bit          m_known = 1'b0;
    bit          m_valid [DEPTH];
    bit [31:0]   m_tag   [DEPTH];
    bit [31:0]   m_tgt   [DEPTH];
    int          m_ctr   [DEPTH];

    function automatic void m_lookup(input bit [31:0] a, output bit taken, output bit [31:0] tgt);
        int unsigned i;
        bit          hit;
        i     = a % DEPTH;
        hit   = m_valid[i] && (m_tag[i] == a / DEPTH);
        taken = hit && (m_ctr[i] >= 2);
        tgt   = hit ? m_tgt[i] : a + 32'd1;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // One cycle of stimulus: drive, predict this cycle's outputs, advance the model.
    task automatic step(input bit r, input bit st, input bit rv, input int kind,
                        input bit ps, input bit z, input bit [31:0] rpc,
                        input bit [31:0] tgt, input bit ptk, input bit [31:0] ptgt);
        exp_t        e;
        bit          act;
        bit          mis;
        bit          ptake;
        bit [31:0]   ptarget;
        int unsigned i;
        @(posedge clk);
        #1;
        rst                 = r;
        bus.stall           = st;
        bus.res_valid       = rv;
        bus.res_kind        = br_kind_e'(kind[1:0]);
        bus.res_ps          = ps;
        bus.res_zero        = z;
        bus.res_pc          = rpc;
        bus.res_target      = tgt;
        bus.res_pred_taken  = ptk;
        bus.res_pred_target = ptgt;

        act = (kind >= 2) ? 1'b1 : ((kind == 1) ? (ps ^ z) : 1'b0);
        mis = rv && ((act != ptk) || (act && ptk && (tgt != ptgt)));
        m_lookup(m_pc, ptake, ptarget);
        if (m_known) begin
            e.pc = m_pc; e.pt = ptake; e.ptgt = ptarget;
            e.fl = mis;  e.fd = m_fd;  e.cnt = 16'(m_cnt);
            exp_q.push_back(e);
        end

        if (r) begin
            m_pc = RESET_PC; m_fd = 1'b0; m_cnt = 0; m_known = 1'b1;
            foreach (m_valid[k]) m_valid[k] = 1'b0;
        end else begin
            if (rv && kind != 0) begin
                i = rpc % DEPTH;
                if (m_valid[i] && m_tag[i] == rpc / DEPTH) begin
                    if (kind >= 2)    m_ctr[i] = 3;
                    else if (act)     m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                    else              m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                    if (act) m_tgt[i] = tgt;
                end else if (act) begin
                    m_valid[i] = 1'b1; m_tag[i] = rpc / DEPTH; m_tgt[i] = tgt;
                    m_ctr[i]   = (kind >= 2) ? 3 : 2;
                end
            end
            if (mis)        m_pc = act ? tgt : rpc + 32'd1;
            else if (st)    m_pc = m_pc;
            else if (ptake) m_pc = ptarget;
            else            m_pc = m_pc + 32'd1;
            m_fd = mis;
            if (mis && m_cnt < 65535) m_cnt++;
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Monitor: compare every presented cycle against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pc",             bus.pc,                    e.pc);
                chk("pred_taken",     32'(bus.pred_taken),       32'(e.pt));
                chk("pred_target",    bus.pred_target,           e.ptgt);
                chk("flush",          32'(bus.flush),            32'(e.fl));
                chk("flush_delay",    32'(bus.flush_delay),      32'(e.fd));
                chk("mispredict_cnt", 32'(bus.mispredict_cnt),   32'(e.cnt));
            end
        end
    end

    initial begin
        bit          r, st, rv, ps, z, ptk, lt;
        int          kind;
        bit [31:0]   rpc, tgt, ptgt, lg;
        rst = 1'b1;
        bus.stall = 1'b0; bus.res_valid = 1'b0; bus.res_kind = BR_NONE;
        bus.res_ps = 1'b0; bus.res_zero = 1'b0; bus.res_pc = '0; bus.res_target = '0;
        bus.res_pred_taken = 1'b0; bus.res_pred_target = '0;

        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(4);
        step(0, 0, 1, 1, 0, 1, 32'h10, 32'h40, 0, 32'h0);   // taken cond, predicted not taken
        idle(1);
        step(0, 0, 1, 3, 0, 0, 32'h5, 32'h10, 0, 32'h0);    // redirect fetch to 0x10
        idle(2);
        step(0, 0, 1, 1, 0, 1, 32'h10, 32'h40, 1, 32'h40);  // correct prediction
        step(0, 0, 1, 1, 0, 1, 32'h10, 32'h40, 1, 32'h40);
        step(0, 0, 1, 2, 0, 0, 32'h10, 32'h80, 1, 32'h40);  // register jump, wrong target
        step(0, 1, 1, 1, 1, 1, 32'h10, 32'h40, 1, 32'h80);  // mispredict under stall
        step(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 3, 0, 0, 32'h20, 32'h99, 0, 32'h0);   // aliases onto 0x10's entry
        step(0, 0, 1, 3, 0, 0, 32'h6, 32'h10, 0, 32'h0);
        idle(2);
        step(0, 0, 1, 1, 1, 1, 32'hFFFF_FFFF, 32'h40, 1, 32'h40); // not-taken redirect wraps
        idle(2);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);                  // mid-run reset
        idle(8);

        for (int n = 0; n < 3000; n++) begin
            r    = ($urandom % 128) == 0;
            st   = ($urandom % 4) == 0;
            rv   = !r && ($urandom % 2 == 1);
            kind = int'($urandom % 4);
            ps   = 1'($urandom);
            z    = 1'($urandom);
            case ($urandom % 5)
                0:       rpc = 32'h10;
                1:       rpc = 32'h20;
                2:       rpc = 32'h11;
                3:       rpc = m_pc;
                default: rpc = $urandom;
            endcase
            case ($urandom % 4)
                0:       tgt = 32'h40;
                1:       tgt = 32'h80;
                2:       tgt = 32'hFFFF_FFFF;
                default: tgt = $urandom;
            endcase
            m_lookup(rpc, lt, lg);
            ptk  = (($urandom % 4) == 0) ? !lt : lt;
            ptgt = (($urandom % 3) == 0) ? tgt : lg;
            step(r, st, rv, kind, ps, z, rpc, tgt, ptk, ptgt);
        end
        idle(2);

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
